// File: rtl/vga_sync_gen.sv
// VGA sync generator: pixel-enable divider, h/v counters, registered sync/bright decode, frame tick.
// Optional FRAME_CNT_EN adds a 16-bit frame counter port (frame_cnt).
module vga_sync_gen #(
  parameter int CLK_DIV  = 4,
  parameter int H_TOTAL  = 800,
  parameter int H_SYNC   = 96,
  parameter int H_START  = 144,
  parameter int H_ACTIVE = 640,
  parameter int V_TOTAL  = 525,
  parameter int V_SYNC   = 2,
  parameter int V_START  = 35,
  parameter int V_ACTIVE = 480
) (
  input  logic       Clk,
  input  logic       Reset,
  output logic       pix_en,
  output logic [9:0] hCount,
  output logic [9:0] vCount,
  output logic       hSync,
  output logic       vSync,
  output logic       bright,
  output logic       frame_tick
`ifdef FRAME_CNT_EN
  ,
  output logic [15:0] frame_cnt
`endif
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [9:0] H_LAST  = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST  = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_SYNC_END = 10'(H_SYNC);
  localparam logic [9:0] V_SYNC_END = 10'(V_SYNC);
  localparam logic [9:0] H_VIS_BEG  = 10'(H_START);
  localparam logic [9:0] H_VIS_END  = 10'(H_START + H_ACTIVE);
  localparam logic [9:0] V_VIS_BEG  = 10'(V_START);
  localparam logic [9:0] V_VIS_END  = 10'(V_START + V_ACTIVE);

  logic [DIV_W-1:0] r_div;
  logic [DIV_W-1:0] w_div_nxt;
  logic [9:0]       r_h;
  logic [9:0]       r_v;
  logic [9:0]       w_h_nxt;
  logic [9:0]       w_v_nxt;
  logic             r_pix_en;
  logic             r_hsync;
  logic             r_vsync;
  logic             r_bright;
  logic             r_frame_tick;
  logic             w_pix_nxt;
  logic             w_tick_nxt;

  // All outputs are decoded from next-state counters so they line up with the registered counters.
  always_comb begin
    w_div_nxt = (r_div == DIV_LAST) ? '0 : r_div + 1'b1;
    w_h_nxt   = r_h;
    w_v_nxt   = r_v;
    if (r_pix_en) begin
      if (r_h == H_LAST) begin
        w_h_nxt = '0;
        w_v_nxt = (r_v == V_LAST) ? '0 : r_v + 1'b1;
      end else begin
        w_h_nxt = r_h + 1'b1;
      end
    end
    w_pix_nxt  = (w_div_nxt == DIV_LAST);
    w_tick_nxt = w_pix_nxt && (w_h_nxt == H_LAST) && (w_v_nxt == V_LAST);
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      r_div        <= '0;
      r_h          <= '0;
      r_v          <= '0;
      r_pix_en     <= 1'b0;
      r_hsync      <= 1'b0;
      r_vsync      <= 1'b0;
      r_bright     <= 1'b0;
      r_frame_tick <= 1'b0;
    end else begin
      r_div        <= w_div_nxt;
      r_h          <= w_h_nxt;
      r_v          <= w_v_nxt;
      r_pix_en     <= w_pix_nxt;
      r_hsync      <= !(w_h_nxt < H_SYNC_END);
      r_vsync      <= !(w_v_nxt < V_SYNC_END);
      r_bright     <= (w_h_nxt >= H_VIS_BEG) && (w_h_nxt < H_VIS_END) &&
                      (w_v_nxt >= V_VIS_BEG) && (w_v_nxt < V_VIS_END);
      r_frame_tick <= w_tick_nxt;
    end
  end

`ifdef FRAME_CNT_EN
  logic [15:0] r_frame_cnt;

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      r_frame_cnt <= '0;
    end else if (r_frame_tick) begin
      r_frame_cnt <= r_frame_cnt + 16'd1;
    end
  end

  assign frame_cnt = r_frame_cnt;
`endif

  assign pix_en     = r_pix_en;
  assign hCount     = r_h;
  assign vCount     = r_v;
  assign hSync      = r_hsync;
  assign vSync      = r_vsync;
  assign bright     = r_bright;
  assign frame_tick = r_frame_tick;

endmodule

// File: tb/tb_vga_sync_gen.sv
// Bench for vga_sync_gen: a full-size instance for line timing and a shrunk instance for frame behaviour.
module tb_vga_sync_gen;

  localparam int A_DIV = 4, A_HT = 800, A_HS = 96, A_HST = 144, A_HA = 640;
  localparam int A_VT = 525, A_VS = 2, A_VST = 35, A_VA = 480;
  localparam int B_DIV = 4, B_HT = 20, B_HS = 3, B_HST = 5, B_HA = 10;
  localparam int B_VT = 12, B_VS = 2, B_VST = 3, B_VA = 6;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_a = 1'b0;
  logic rst_b = 1'b0;
  logic pix_a, hs_a, vs_a, br_a, ft_a;
  logic pix_b, hs_b, vs_b, br_b, ft_b;
  logic [9:0] h_a, v_a, h_b, v_b;
`ifdef FRAME_CNT_EN
  logic [15:0] fc_a, fc_b;
`endif

  vga_sync_gen dut_a (
    .Clk(clk), .Reset(rst_a), .pix_en(pix_a), .hCount(h_a), .vCount(v_a),
    .hSync(hs_a), .vSync(vs_a), .bright(br_a), .frame_tick(ft_a)
`ifdef FRAME_CNT_EN
    , .frame_cnt(fc_a)
`endif
  );

  vga_sync_gen #(
    .CLK_DIV(B_DIV), .H_TOTAL(B_HT), .H_SYNC(B_HS), .H_START(B_HST), .H_ACTIVE(B_HA),
    .V_TOTAL(B_VT), .V_SYNC(B_VS), .V_START(B_VST), .V_ACTIVE(B_VA)
  ) dut_b (
    .Clk(clk), .Reset(rst_b), .pix_en(pix_b), .hCount(h_b), .vCount(v_b),
    .hSync(hs_b), .vSync(vs_b), .bright(br_b), .frame_tick(ft_b)
`ifdef FRAME_CNT_EN
    , .frame_cnt(fc_b)
`endif
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model: every output follows from the number of clock edges since reset release.
  typedef struct {
    int h; int v; int pix; int hs; int vs; int br; int ft; int frames;
  } exp_t;

  function automatic exp_t model(input int t, input int d, input int ht, input int hsw,
                                 input int hst, input int ha, input int vt, input int vsw,
                                 input int vst, input int va);
    exp_t e;
    int p;
    p        = t / d;
    e.h      = p % ht;
    e.v      = (p / ht) % vt;
    e.pix    = ((t % d) == d - 1) ? 1 : 0;
    e.hs     = (e.h >= hsw) ? 1 : 0;
    e.vs     = (e.v >= vsw) ? 1 : 0;
    e.br     = (e.h >= hst && e.h < hst + ha && e.v >= vst && e.v < vst + va) ? 1 : 0;
    e.ft     = (e.pix == 1 && e.h == ht - 1 && e.v == vt - 1) ? 1 : 0;
    e.frames = p / (ht * vt);
    return e;
  endfunction

  int ta = 0;
  int tb_t = 0;
  always @(posedge clk) begin
    ta   <= rst_a ? ta + 1 : 0;
    tb_t <= rst_b ? tb_t + 1 : 0;
  end

  exp_t ea, eb;
  int fc_base_b = 0;
  int seg_b = 0;
  int a_hs_low = 0, a_h3199 = -1, a_v3199 = -1, a_h3200 = -1, a_v3200 = -1;
  int b_br = 0, b_vs_low = 0, n_ticks = 0;
  int tick_t[3];

  always @(negedge clk) begin
    ea = model(rst_a ? ta : 0, A_DIV, A_HT, A_HS, A_HST, A_HA, A_VT, A_VS, A_VST, A_VA);
    eb = model(rst_b ? tb_t : 0, B_DIV, B_HT, B_HS, B_HST, B_HA, B_VT, B_VS, B_VST, B_VA);
    chk("a_hcount", int'(h_a), ea.h);
    chk("a_vcount", int'(v_a), ea.v);
    chk("a_pix_en", int'(pix_a), ea.pix);
    chk("a_hsync", int'(hs_a), ea.hs);
    chk("a_vsync", int'(vs_a), ea.vs);
    chk("a_bright", int'(br_a), ea.br);
    chk("a_frame_tick", int'(ft_a), ea.ft);
    chk("b_hcount", int'(h_b), eb.h);
    chk("b_vcount", int'(v_b), eb.v);
    chk("b_pix_en", int'(pix_b), eb.pix);
    chk("b_hsync", int'(hs_b), eb.hs);
    chk("b_vsync", int'(vs_b), eb.vs);
    chk("b_bright", int'(br_b), eb.br);
    chk("b_frame_tick", int'(ft_b), eb.ft);
`ifdef FRAME_CNT_EN
    chk("a_frame_cnt", int'(fc_a), ea.frames & 32'hFFFF);
    chk("b_frame_cnt", int'(fc_b), (fc_base_b + eb.frames) & 32'hFFFF);
`endif
    if (rst_a && ta < 3200 && !hs_a) a_hs_low++;
    if (rst_a && ta == 3199) begin a_h3199 = int'(h_a); a_v3199 = int'(v_a); end
    if (rst_a && ta == 3200) begin a_h3200 = int'(h_a); a_v3200 = int'(v_a); end
    if (seg_b == 0 && rst_b) begin
      if (tb_t < 960 && pix_b && br_b) b_br++;
      if (tb_t < 960 && !vs_b) b_vs_low++;
      if (ft_b) begin
        if (n_ticks < 3) tick_t[n_ticks] = tb_t;
        n_ticks++;
      end
    end
  end

  initial begin
    bit found;
    repeat (2) @(posedge clk);
    #2;
    chk("rst_a_hcount", int'(h_a), 0);
    chk("rst_a_vcount", int'(v_a), 0);
    chk("rst_a_hsync", int'(hs_a), 0);
    chk("rst_a_vsync", int'(vs_a), 0);
    chk("rst_a_bright", int'(br_a), 0);
    chk("rst_a_pix_en", int'(pix_a), 0);
    rst_a = 1'b1;
    rst_b = 1'b1;
    repeat (2) @(posedge clk);
    #1 chk("a_pix_en_cycle3", int'(pix_a), 0);
    @(posedge clk);
    #1 chk("a_pix_en_cycle4", int'(pix_a), 1);
    chk("a_hcount_cycle4", int'(h_a), 0);
    @(posedge clk);
    #1 chk("a_hcount_after_first_pix", int'(h_a), 1);

    for (int i = 0; i < 5000 && tb_t < 2900; i++) @(posedge clk);
    chk("b_wait_3_frames", (tb_t >= 2900) ? 1 : 0, 1);
    chk("b_tick_count", n_ticks, 3);
    chk("b_tick0_time", tick_t[0], 959);
    chk("b_tick1_time", tick_t[1], 1919);
    chk("b_tick2_time", tick_t[2], 2879);
    chk("b_bright_pix_per_frame", b_br, 60);
    chk("b_vsync_low_clks", b_vs_low, 160);
    seg_b = 1;

    found = 1'b0;
    for (int i = 0; i < 2000 && !found; i++) begin
      @(posedge clk);
      #2;
      if (h_b == 10'd12 && v_b == 10'd7) found = 1'b1;
    end
    chk("b_reach_midframe", found ? 1 : 0, 1);
    rst_b = 1'b0;
    #1;
    chk("async_rst_hcount", int'(h_b), 0);
    chk("async_rst_vcount", int'(v_b), 0);
    chk("async_rst_hsync", int'(hs_b), 0);
    chk("async_rst_vsync", int'(vs_b), 0);
    chk("async_rst_bright", int'(br_b), 0);
    chk("async_rst_pix_en", int'(pix_b), 0);
    repeat (2) @(posedge clk);
    #2 rst_b = 1'b1;
`ifdef FRAME_CNT_EN
    fc_base_b = 32'hFFFE;
    force dut_b.r_frame_cnt = 16'hFFFE;
    #1 release dut_b.r_frame_cnt;
`endif
    repeat (3) @(posedge clk);
    #1 chk("b_pix_en_after_rst", int'(pix_b), 1);
    @(posedge clk);
    #1 chk("b_hcount_after_rst", int'(h_b), 1);

    for (int i = 0; i < 2000 && tb_t < 1000; i++) @(posedge clk);
    #1;
`ifdef FRAME_CNT_EN
    chk("b_frame_cnt_ffff", int'(fc_b), 32'hFFFF);
`endif
    for (int i = 0; i < 2000 && tb_t < 1930; i++) @(posedge clk);
    #1;
    chk("b_wait_2_frames", (tb_t >= 1930) ? 1 : 0, 1);
`ifdef FRAME_CNT_EN
    chk("b_frame_cnt_wrap", int'(fc_b), 0);
`endif

    for (int i = 0; i < 5000 && ta < 3300; i++) @(posedge clk);
    #1;
    chk("a_hsync_low_clks", a_hs_low, 384);
    chk("a_hcount_t3199", a_h3199, 799);
    chk("a_vcount_t3199", a_v3199, 0);
    chk("a_hcount_t3200", a_h3200, 0);
    chk("a_vcount_t3200", a_v3200, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
